// File: rtl/debug_loader_ctrl_pkg.sv
// Shared command opcodes, FSM state encodings and command-word field positions
// for the debug/loader sequencer.
package debug_loader_ctrl_pkg;

  localparam int unsigned OPCODE_MSB   = 31;
  localparam int unsigned OPCODE_LSB   = 24;
  localparam int unsigned COUNT_MSB    = 15;
  localparam int unsigned OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;

  localparam opcode_t CMD_LOAD   = 8'h01;
  localparam opcode_t CMD_RUN    = 8'h02;
  localparam opcode_t CMD_STEP   = 8'h03;
  localparam opcode_t CMD_DUMP   = 8'h04;
  localparam opcode_t CMD_PRESET = 8'h05;
  localparam opcode_t CMD_HALT   = 8'h06;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_RUN       = 3'd2;
  localparam logic [2:0] ST_STEP      = 3'd3;
  localparam logic [2:0] ST_DUMP_SEL  = 3'd4;
  localparam logic [2:0] ST_DUMP_SEND = 3'd5;
  localparam logic [2:0] ST_DUMP_WAIT = 3'd6;

  function automatic opcode_t get_opcode(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/debug_loader_ctrl_if.sv
// Word-level bus of the debug loader: RX word stream in, instruction-memory
// write port out, TX word handshake out.
interface debug_loader_ctrl_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned IMEM_ADDR_WIDTH = 10
);

  logic [DATA_WIDTH-1:0]      i_word;
  logic                       i_word_valid;
  logic                       i_tx_busy;
  logic                       i_tx_done;
  logic                       o_imem_we;
  logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr;
  logic [DATA_WIDTH-1:0]      o_imem_data;
  logic                       o_tx_start;
  logic [DATA_WIDTH-1:0]      o_tx_data;

  modport master (
    input  i_word, i_word_valid, i_tx_busy, i_tx_done,
    output o_imem_we, o_imem_addr, o_imem_data, o_tx_start, o_tx_data
  );

  modport slave (
    output i_word, i_word_valid, i_tx_busy, i_tx_done,
    input  o_imem_we, o_imem_addr, o_imem_data, o_tx_start, o_tx_data
  );

endinterface

// File: rtl/debug_loader_ctrl_tx_seq.sv
// Dump sequencer: walks the register file, then PC (and an optional extra word),
// sending each through the TX word handshake.
module dbg_tx_sequencer
  import debug_loader_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NB_REGS       = 32,
  parameter int unsigned REG_SEL_WIDTH = 5,
  parameter int unsigned NB_WORDS      = 33
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [DATA_WIDTH-1:0]    i_reg_data,
  input  logic [DATA_WIDTH-1:0]    i_pc,
  input  logic [DATA_WIDTH-1:0]    i_extra_word,
  input  logic                     i_tx_busy,
  input  logic                     i_tx_done,
  output logic [REG_SEL_WIDTH-1:0] o_reg_sel,
  output logic                     o_tx_start,
  output logic [DATA_WIDTH-1:0]    o_tx_data,
  output logic                     o_done,
  output logic [2:0]               o_state_next
);

  localparam int unsigned IdxWidth = $clog2(NB_WORDS);
  localparam logic [IdxWidth-1:0] PcIdx   = IdxWidth'(NB_REGS);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NB_WORDS - 1);

  logic [2:0]               state_q, state_d;
  logic [IdxWidth-1:0]      idx_q, idx_d;
  logic [REG_SEL_WIDTH-1:0] reg_sel_q, reg_sel_d;
  logic                     tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0]    send_word;

  always_comb begin
    if (idx_q < PcIdx) begin
      send_word = i_reg_data;
    end else if (idx_q == PcIdx) begin
      send_word = i_pc;
    end else begin
      send_word = i_extra_word;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    reg_sel_d  = reg_sel_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    o_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          idx_d   = '0;
          state_d = ST_DUMP_SEL;
        end
      end
      ST_DUMP_SEL: begin
        // Non-register words keep the last select; their data comes from other inputs.
        if (idx_q < PcIdx) reg_sel_d = REG_SEL_WIDTH'(idx_q);
        state_d = ST_DUMP_SEND;
      end
      ST_DUMP_SEND: begin
        if (!i_tx_busy) begin
          tx_data_d  = send_word;
          tx_start_d = 1'b1;
          state_d    = ST_DUMP_WAIT;
        end
      end
      ST_DUMP_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == LastIdx) begin
            o_done  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_DUMP_SEL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      reg_sel_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      reg_sel_q  <= reg_sel_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_reg_sel    = reg_sel_q;
  assign o_tx_start   = tx_start_q;
  assign o_tx_data    = tx_data_q;
  assign o_state_next = state_d;

endmodule

// File: rtl/debug_loader_ctrl.sv
// Debug/loader sequencer: decodes UART command words, loads instruction memory,
// gates the pipeline and dumps state. DBG_CYCLE_COUNT_EN adds a run-cycle counter.
module debug_loader_ctrl
  import debug_loader_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned IMEM_ADDR_WIDTH = 10,
  parameter int unsigned NB_REGS         = 32,
  parameter int unsigned REG_SEL_WIDTH   = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  debug_loader_ctrl_if.master      bus,
  input  logic                     i_halt,
  input  logic [DATA_WIDTH-1:0]    i_pc,
  input  logic [DATA_WIDTH-1:0]    i_reg_data,
  output logic                     o_pipe_en,
  output logic                     o_pipe_reset,
  output logic [REG_SEL_WIDTH-1:0] o_reg_sel,
  output logic                     o_err,
  output logic [2:0]               o_state
);

`ifdef DBG_CYCLE_COUNT_EN
  localparam int unsigned NbWords = NB_REGS + 2;
`else
  localparam int unsigned NbWords = NB_REGS + 1;
`endif

  logic [2:0]                 state_q, state_d;
  logic [2:0]                 ostate_q, ostate_d;
  logic [15:0]                count_q, count_d;
  logic                       imem_we_q, imem_we_d;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0]      imem_data_q, imem_data_d;
  logic                       pipe_en_q, pipe_en_d;
  logic                       pipe_reset_q, pipe_reset_d;
  logic                       err_q, err_d;
  logic                       dump_start, dump_done;
  logic [2:0]                 seq_state_d;
  logic [DATA_WIDTH-1:0]      extra_word;
  logic [15:0]                word_count;
  logic                       halt_req;
  opcode_t                    opcode;

  assign opcode     = get_opcode(bus.i_word);
  assign word_count = bus.i_word[COUNT_MSB:0];
  assign halt_req   = i_halt || (bus.i_word_valid && (opcode == CMD_HALT));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    imem_we_d    = 1'b0;
    // Address advances in the cycle the write is presented.
    imem_addr_d  = imem_we_q ? imem_addr_q + 1'b1 : imem_addr_q;
    imem_data_d  = imem_data_q;
    pipe_en_d    = 1'b0;
    pipe_reset_d = 1'b0;
    err_d        = 1'b0;
    dump_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_word_valid) begin
          case (opcode)
            CMD_LOAD: begin
              count_d     = word_count;
              imem_addr_d = '0;
              if (word_count != '0) state_d = ST_LOAD;
            end
            CMD_RUN: begin
              state_d   = ST_RUN;
              pipe_en_d = 1'b1;
            end
            CMD_STEP: begin
              if (i_halt) begin
                err_d = 1'b1;
              end else begin
                state_d   = ST_STEP;
                pipe_en_d = 1'b1;
              end
            end
            CMD_DUMP: begin
              state_d    = ST_DUMP_SEL;
              dump_start = 1'b1;
            end
            CMD_PRESET: pipe_reset_d = 1'b1;
            default:    err_d        = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        if (bus.i_word_valid) begin
          imem_we_d   = 1'b1;
          imem_data_d = bus.i_word;
          count_d     = count_q - 1'b1;
          if (count_q == 16'd1) state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_IDLE;
        end else begin
          pipe_en_d = 1'b1;
          err_d     = bus.i_word_valid;
        end
      end
      ST_STEP: begin
        state_d = ST_IDLE;
        err_d   = bus.i_word_valid;
      end
      ST_DUMP_SEL: begin
        // The whole dump is delegated; the sub-sequencer reports the finer state.
        err_d = bus.i_word_valid;
        if (dump_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ostate_d = (state_d == ST_DUMP_SEL) ? seq_state_d : state_d;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      ostate_q     <= ST_IDLE;
      count_q      <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      pipe_en_q    <= 1'b0;
      pipe_reset_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ostate_q     <= ostate_d;
      count_q      <= count_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      pipe_en_q    <= pipe_en_d;
      pipe_reset_q <= pipe_reset_d;
      err_q        <= err_d;
    end
  end

`ifdef DBG_CYCLE_COUNT_EN
  logic [DATA_WIDTH-1:0] cyc_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset || pipe_reset_d) begin
      cyc_cnt_q <= '0;
    end else if (pipe_en_q) begin
      cyc_cnt_q <= cyc_cnt_q + 1'b1;
    end
  end

  assign extra_word = cyc_cnt_q;
`else
  assign extra_word = '0;
`endif

  dbg_tx_sequencer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NB_REGS       (NB_REGS),
    .REG_SEL_WIDTH (REG_SEL_WIDTH),
    .NB_WORDS      (NbWords)
  ) u_tx_seq (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (dump_start),
    .i_reg_data   (i_reg_data),
    .i_pc         (i_pc),
    .i_extra_word (extra_word),
    .i_tx_busy    (bus.i_tx_busy),
    .i_tx_done    (bus.i_tx_done),
    .o_reg_sel    (o_reg_sel),
    .o_tx_start   (bus.o_tx_start),
    .o_tx_data    (bus.o_tx_data),
    .o_done       (dump_done),
    .o_state_next (seq_state_d)
  );

  assign bus.o_imem_we   = imem_we_q;
  assign bus.o_imem_addr = imem_addr_q;
  assign bus.o_imem_data = imem_data_q;
  assign o_pipe_en       = pipe_en_q;
  assign o_pipe_reset    = pipe_reset_q;
  assign o_err           = err_q;
  assign o_state         = ostate_q;

endmodule

// File: doc/debug_loader_ctrl.md
Name: debug_loader_ctrl

Overview:
- Debug/loader sequencer between the UART word assembler and the pipeline.
- Consumes 32-bit words plus a one-cycle done pulse, and decodes command words.
- Streams instruction words into instruction memory.
- Gates the pipeline clock-enable for RUN and STEP.
- Serialises register file + PC back out through the UART TX word handshake.

Parameters:
- DATA_WIDTH, 32, width of received/transmitted words and pipeline registers
- IMEM_ADDR_WIDTH, 10, instruction memory word-address width
- NB_REGS, 32, number of register-file entries dumped
- REG_SEL_WIDTH, 5, register-select width (clog2 NB_REGS)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-low reset
- i_word  in  DATA_WIDTH  assembled instruction or command word
- i_word_valid  in  1  one-cycle pulse, i_word valid
- i_halt  in  1  pipeline reached HALT instruction (level)
- i_pc  in  DATA_WIDTH  current pipeline PC
- i_reg_data  in  DATA_WIDTH  register file read data (combinational on o_reg_sel)
- i_tx_busy  in  1  TX word serialiser busy
- i_tx_done  in  1  one-cycle pulse, TX word finished
- o_imem_we  out  1  instruction memory write enable
- o_imem_addr  out  IMEM_ADDR_WIDTH  write address
- o_imem_data  out  DATA_WIDTH  write data
- o_pipe_en  out  1  pipeline advance enable
- o_pipe_reset  out  1  pipeline soft reset pulse
- o_reg_sel  out  REG_SEL_WIDTH  register read select
- o_tx_start  out  1  one-cycle TX start pulse
- o_tx_data  out  DATA_WIDTH  word to transmit
- o_err  out  1  one-cycle pulse, illegal/dropped word
- o_state  out  3  current FSM state, for LEDs

Behaviour:
- Reset (i_reset==0 at posedge):
  - state=IDLE.
  - All outputs 0; load address/count, dump index and tx pending cleared.
  - Applies mid-operation too: a partial LOAD or DUMP is abandoned.
- All outputs are registered.
- Opcode = i_word[31:24] in IDLE:
  - 0x01 LOAD: count=i_word[15:0].
  - 0x02 RUN.
  - 0x03 STEP.
  - 0x04 DUMP.
  - 0x05 PRESET.
  - 0x06 HALT: honoured only in RUN; in IDLE it is an unknown opcode.
  - Any other opcode: o_err pulse, stay IDLE.
- LOAD:
  - count==0 -> back to IDLE, no writes.
  - Otherwise the next count valid words are raw instructions, not decoded.
  - Each word: o_imem_we=1 for exactly one cycle, the cycle after i_word_valid.
  - o_imem_data=word; o_imem_addr starts at 0 and increments after each write.
  - Address wraps modulo 2^IMEM_ADDR_WIDTH.
  - After the count-th write -> IDLE.
- RUN:
  - o_pipe_en=1 from the cycle after the command until exit.
  - Exit on i_halt==1 or a valid HALT word: o_pipe_en=0 the next cycle, ->IDLE.
  - i_halt and HALT word in the same cycle: single exit, no o_err.
  - Other words in RUN: dropped, o_err pulse.
- STEP:
  - o_pipe_en=1 for exactly one cycle, then IDLE.
  - Ignored (o_err, stay IDLE) if i_halt==1.
- PRESET: o_pipe_reset=1 for one cycle, ->IDLE.
- DUMP transmits NB_REGS+1 words: reg0..reg(NB_REGS-1), then i_pc.
  - DUMP_SEL: set o_reg_sel=idx.
  - DUMP_SEND: wait until i_tx_busy==0, then latch o_tx_data and pulse o_tx_start one cycle.
  - DUMP_WAIT: wait for i_tx_done, then idx++.
  - After the final word -> IDLE.
  - i_word_valid during DUMP: dropped, o_err pulse.
- o_state encoding:
  - IDLE=0
  - LOAD=1
  - RUN=2
  - STEP=3
  - DUMP_SEL=4
  - DUMP_SEND=5
  - DUMP_WAIT=6

Optional Feature:
- Macro DBG_CYCLE_COUNT_EN.
- Defined:
  - 32-bit counter increments every cycle o_pipe_en==1; cleared by reset and PRESET.
  - DUMP appends it as a final word, so NB_REGS+2 words total.
- Undefined: no counter; dump is NB_REGS+1 words.

Decomposition:
- Shared package holds:
  - opcode constants (CMD_LOAD..CMD_HALT)
  - state encodings
  - OPCODE_MSB/LSB field positions
- One sub-module is natural: dbg_tx_sequencer, owning DUMP_SEL/SEND/WAIT, the index counter and the TX handshake.
- The top FSM hands off with a start pulse and waits for its done pulse.

Test Plan:
- Reset during LOAD after 2 of 4 words -> all outputs 0 next cycle; new LOAD count=1 writes addr 0.
- LOAD count=3, words 0xAAAA0001/0xBBBB0002/0xCCCC0003 -> three single-cycle o_imem_we pulses at addr 0,1,2 with matching data; o_state returns 0.
- RUN, assert i_halt 20 cycles later -> o_pipe_en high exactly 20 cycles; HALT word and i_halt together -> one exit, no o_err.
- STEP x3 -> three single-cycle o_pipe_en pulses; STEP with i_halt=1 -> o_err, no pulse.
- DUMP with reg[k]=k*4, i_pc=0x40, i_tx_busy held 5 cycles per word -> 33 o_tx_start pulses (34 with DBG_CYCLE_COUNT_EN), data 0,4,...,124,0x40 in order; word injected mid-dump -> o_err.
- Opcode 0x7F in IDLE -> o_err pulse, state IDLE, no other output change.
